// File: rtl/ace_snoop_bcast.sv
// Snoop broadcast and response-merge engine: fans one coherent request out as AC snoops,
// merges the CR responses, forwards one CD line and drains the rest.
module ace_snoop_bcast #(
    parameter int NoPorts   = 4,
    parameter int AddrWidth = 64,
    parameter int DataWidth = 64,
    localparam int PortIdxW = (NoPorts > 2) ? $clog2(NoPorts) : 1
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         req_valid_i,
    output logic                         req_ready_o,
    input  logic [AddrWidth-1:0]         req_addr_i,
    input  logic [3:0]                   req_snoop_i,
    input  logic [PortIdxW-1:0]          req_port_i,
    input  logic [NoPorts-1:0]           snp_en_i,
    output logic [NoPorts-1:0]           ac_valid_o,
    input  logic [NoPorts-1:0]           ac_ready_i,
    output logic [AddrWidth-1:0]         ac_addr_o,
    output logic [3:0]                   ac_snoop_o,
    input  logic [NoPorts-1:0]           cr_valid_i,
    output logic [NoPorts-1:0]           cr_ready_o,
    input  logic [5*NoPorts-1:0]         cr_resp_i,
    input  logic [NoPorts-1:0]           cd_valid_i,
    output logic [NoPorts-1:0]           cd_ready_o,
    input  logic [DataWidth*NoPorts-1:0] cd_data_i,
    input  logic [NoPorts-1:0]           cd_last_i,
    output logic                         rsp_valid_o,
    input  logic                         rsp_ready_i,
    output logic                         rsp_data_o,
    output logic                         rsp_pass_dirty_o,
    output logic                         rsp_is_shared_o,
    output logic                         rsp_was_unique_o,
    output logic                         rsp_err_o,
    output logic                         dat_valid_o,
    input  logic                         dat_ready_i,
    output logic [DataWidth-1:0]         dat_data_o,
    output logic                         dat_last_o
);

    // state | meaning
    // IDLE  | ready for a request
    // SNOOP | AC snoops outstanding and/or CR responses pending
    // RESP  | merged response presented, waiting for rsp_ready_i
    // DATA  | forwarding the selected CD stream, discarding the others
    typedef enum logic [1:0] {IDLE, SNOOP, RESP, DATA} state_e;

    state_e state_q, state_d;

    logic [AddrWidth-1:0]    ac_addr_q;
    logic [3:0]              ac_snoop_q;
    logic [NoPorts-1:0]      ac_pend_q, cr_pend_q, drain_q;
    logic [NoPorts-1:0][4:0] resp_q, resp_d;
    logic [PortIdxW-1:0]     sel_q, sel_d;
    logic                    fwd_q, pass_dirty_q, is_shared_q, was_unique_q, err_q;

    logic [NoPorts-1:0] tgt, ac_hs, cr_hs, cd_hs, ac_pend_d, cr_pend_d, drain_left;
    logic [NoPorts-1:0] dt, dirty_dt, drain_m, shared_v, unique_v, err_v;
    logic               snoop_done;

    function automatic logic [PortIdxW-1:0] first_set(input logic [NoPorts-1:0] v);
        first_set = '0;
        for (int i = NoPorts - 1; i >= 0; i--) begin
            if (v[i]) first_set = PortIdxW'(i);
        end
    endfunction

    assign tgt        = snp_en_i & ~(NoPorts'(1) << req_port_i);
    assign ac_hs      = ac_valid_o & ac_ready_i;
    assign cr_hs      = cr_valid_i & cr_ready_o;
    assign cd_hs      = cd_valid_i & cd_ready_o;
    assign ac_pend_d  = ac_pend_q & ~ac_hs;
    assign cr_pend_d  = cr_pend_q & ~cr_hs;
    assign snoop_done = ~|ac_pend_d & ~|cr_pend_d;
    assign drain_left = drain_q & ~(cd_hs & cd_last_i);

    // Merge sees this cycle's CR captures so the SNOOP exit needs no extra cycle.
    always_comb begin
        resp_d = resp_q;
        for (int i = 0; i < NoPorts; i++) begin
            if (cr_hs[i]) resp_d[i] = cr_resp_i[5*i +: 5];
        end
        for (int i = 0; i < NoPorts; i++) begin
            dt[i]       = resp_d[i][0] & ~resp_d[i][1];
            dirty_dt[i] = resp_d[i][0] & ~resp_d[i][1] & resp_d[i][2];
            drain_m[i]  = resp_d[i][0];
            err_v[i]    = resp_d[i][1];
            shared_v[i] = resp_d[i][3];
            unique_v[i] = resp_d[i][4];
        end
        sel_d = (|dirty_dt) ? first_set(dirty_dt) : first_set(dt);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_valid_i) state_d = (tgt == '0) ? RESP : SNOOP;
            SNOOP:   if (snoop_done) state_d = RESP;
            RESP:    if (rsp_ready_i) state_d = (drain_q != '0) ? DATA : IDLE;
            DATA:    if (drain_left == '0) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready_o = (state_q == IDLE);
        ac_valid_o  = '0;
        cr_ready_o  = '0;
        cd_ready_o  = '0;
        rsp_valid_o = 1'b0;
        dat_valid_o = 1'b0;
        dat_data_o  = '0;
        dat_last_o  = 1'b0;
        case (state_q)
            SNOOP: begin
                ac_valid_o = ac_pend_q;
                cr_ready_o = cr_pend_q & ~ac_pend_q;
            end
            RESP: rsp_valid_o = 1'b1;
            DATA: begin
                cd_ready_o = drain_q;
                if (fwd_q) begin
                    cd_ready_o[sel_q] = drain_q[sel_q] & dat_ready_i;
                    dat_valid_o       = drain_q[sel_q] & cd_valid_i[sel_q];
                    dat_data_o        = cd_data_i[sel_q*DataWidth +: DataWidth];
                    dat_last_o        = cd_last_i[sel_q];
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ac_addr_q    <= '0;
            ac_snoop_q   <= '0;
            ac_pend_q    <= '0;
            cr_pend_q    <= '0;
            drain_q      <= '0;
            resp_q       <= '0;
            sel_q        <= '0;
            fwd_q        <= 1'b0;
            pass_dirty_q <= 1'b0;
            is_shared_q  <= 1'b0;
            was_unique_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (req_valid_i) begin
                    ac_addr_q    <= req_addr_i;
                    ac_snoop_q   <= req_snoop_i;
                    ac_pend_q    <= tgt;
                    cr_pend_q    <= tgt;
                    drain_q      <= '0;
                    resp_q       <= '0;
                    sel_q        <= '0;
                    fwd_q        <= 1'b0;
                    pass_dirty_q <= 1'b0;
                    is_shared_q  <= 1'b0;
                    was_unique_q <= 1'b0;
                    err_q        <= 1'b0;
                end
                SNOOP: begin
                    ac_pend_q <= ac_pend_d;
                    cr_pend_q <= cr_pend_d;
                    resp_q    <= resp_d;
                    if (snoop_done) begin
                        drain_q      <= drain_m;
                        sel_q        <= sel_d;
                        fwd_q        <= |dt;
                        pass_dirty_q <= |dirty_dt;
                        is_shared_q  <= |shared_v;
                        was_unique_q <= |unique_v;
                        err_q        <= |err_v;
                    end
                end
                DATA: drain_q <= drain_left;
                default: ;
            endcase
        end
    end

    assign ac_addr_o        = ac_addr_q;
    assign ac_snoop_o       = ac_snoop_q;
    assign rsp_data_o       = fwd_q;
    assign rsp_pass_dirty_o = pass_dirty_q;
    assign rsp_is_shared_o  = is_shared_q;
    assign rsp_was_unique_o = was_unique_q;
    assign rsp_err_o        = err_q;

endmodule

// File: tb/tb_ace_snoop_bcast.sv
// Bench for ace_snoop_bcast: directed scenarios plus randomized transactions checked
// against a transaction-level model of the snoop/merge/forward rules.
module tb_ace_snoop_bcast;

    localparam int NP = 4;
    localparam int AW = 64;
    localparam int DW = 64;

    logic clk_i = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk_i = ~clk_i;

    logic               req_valid_i, req_ready_o;
    logic [AW-1:0]      req_addr_i;
    logic [3:0]         req_snoop_i;
    logic [1:0]         req_port_i;
    logic [NP-1:0]      snp_en_i;
    logic [NP-1:0]      ac_valid_o, ac_ready_i;
    logic [AW-1:0]      ac_addr_o;
    logic [3:0]         ac_snoop_o;
    logic [NP-1:0]      cr_valid_i, cr_ready_o;
    logic [5*NP-1:0]    cr_resp_i;
    logic [NP-1:0]      cd_valid_i, cd_ready_o, cd_last_i;
    logic [DW*NP-1:0]   cd_data_i;
    logic               rsp_valid_o, rsp_ready_i, rsp_data_o;
    logic               rsp_pass_dirty_o, rsp_is_shared_o, rsp_was_unique_o, rsp_err_o;
    logic               dat_valid_o, dat_ready_i, dat_last_o;
    logic [DW-1:0]      dat_data_o;

    ace_snoop_bcast #(.NoPorts(NP), .AddrWidth(AW), .DataWidth(DW)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
        .req_snoop_i(req_snoop_i), .req_port_i(req_port_i), .snp_en_i(snp_en_i),
        .ac_valid_o(ac_valid_o), .ac_ready_i(ac_ready_i), .ac_addr_o(ac_addr_o),
        .ac_snoop_o(ac_snoop_o), .cr_valid_i(cr_valid_i), .cr_ready_o(cr_ready_o),
        .cr_resp_i(cr_resp_i), .cd_valid_i(cd_valid_i), .cd_ready_o(cd_ready_o),
        .cd_data_i(cd_data_i), .cd_last_i(cd_last_i), .rsp_valid_o(rsp_valid_o),
        .rsp_ready_i(rsp_ready_i), .rsp_data_o(rsp_data_o), .rsp_pass_dirty_o(rsp_pass_dirty_o),
        .rsp_is_shared_o(rsp_is_shared_o), .rsp_was_unique_o(rsp_was_unique_o),
        .rsp_err_o(rsp_err_o), .dat_valid_o(dat_valid_o), .dat_ready_i(dat_ready_i),
        .dat_data_o(dat_data_o), .dat_last_o(dat_last_o)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Transaction configuration
    logic [1:0]  t_port;
    logic [3:0]  t_en;
    logic [63:0] t_addr;
    logic [3:0]  t_snoop;
    logic [4:0]  t_resp [NP];
    int          t_nb   [NP];
    logic [63:0] t_beat [NP][8];
    int          ac_at  [NP];
    int          cr_at  [NP];

    task automatic idle_inputs();
        req_valid_i = 1'b0; req_addr_i = '0; req_snoop_i = '0; req_port_i = '0;
        snp_en_i = '0; ac_ready_i = '0; cr_valid_i = '0; cr_resp_i = '0;
        cd_valid_i = '0; cd_data_i = '0; cd_last_i = '0;
        rsp_ready_i = 1'b0; dat_ready_i = 1'b0;
    endtask

    task automatic cfg_default(input logic [1:0] port, input logic [3:0] en);
        t_port = port; t_en = en;
        t_addr = {$urandom, $urandom}; t_snoop = 4'($urandom);
        for (int i = 0; i < NP; i++) begin
            t_resp[i] = '0; t_nb[i] = 1; ac_at[i] = 1; cr_at[i] = 1;
            for (int b = 0; b < 8; b++) t_beat[i][b] = {$urandom, $urandom};
        end
    endtask

    task automatic cfg_random();
        cfg_default(2'($urandom_range(3, 0)), 4'($urandom));
        for (int i = 0; i < NP; i++) begin
            t_resp[i][0] = 1'($urandom_range(1, 0));
            t_resp[i][1] = ($urandom_range(4, 0) == 0);
            t_resp[i][2] = ($urandom_range(2, 0) == 0);
            t_resp[i][3] = ($urandom_range(2, 0) == 0);
            t_resp[i][4] = ($urandom_range(2, 0) == 0);
            t_nb[i] = $urandom_range(4, 1);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, req_ready_o, 1);
        chk({tag, "_ac_valid"}, ac_valid_o, 0);
        chk({tag, "_cr_ready"}, cr_ready_o, 0);
        chk({tag, "_cd_ready"}, cd_ready_o, 0);
        chk({tag, "_rsp_valid"}, rsp_valid_o, 0);
        chk({tag, "_dat_valid"}, dat_valid_o, 0);
        chk({tag, "_ac_addr"}, ac_addr_o, 0);
        chk({tag, "_ac_snoop"}, ac_snoop_o, 0);
        chk({tag, "_flags"}, {rsp_data_o, rsp_pass_dirty_o, rsp_is_shared_o,
                              rsp_was_unique_o, rsp_err_o}, 0);
    endtask

    task automatic run_txn(input bit scripted, input int exp_rsp_cyc, input int rst_beat);
        logic [3:0] tgt, drain, ac_done, cr_done, exp_cd_rdy;
        bit fwd, pd, is, wu, er, rsp_done, snooping, in_resp, in_data, any_rem, fin, exp_dat_v;
        int sel, first_dt, first_dirty, rsp_cyc, fwd_cnt;
        int idx [NP];

        // Reference merge from the recorded responses of the snooped ports
        tgt = t_en & ~(4'b0001 << t_port);
        first_dt = -1; first_dirty = -1; is = 0; wu = 0; er = 0; drain = '0;
        for (int i = 0; i < NP; i++) begin
            if (tgt[i]) begin
                is |= t_resp[i][3]; wu |= t_resp[i][4]; er |= t_resp[i][1];
                drain[i] = t_resp[i][0];
                if (t_resp[i][0] && !t_resp[i][1]) begin
                    if (first_dt < 0) first_dt = i;
                    if (t_resp[i][2] && first_dirty < 0) first_dirty = i;
                end
            end
        end
        fwd = (first_dt >= 0);
        sel = (first_dirty >= 0) ? first_dirty : (fwd ? first_dt : 0);
        pd  = fwd && t_resp[sel][2];

        @(negedge clk_i);
        req_valid_i = 1'b1; req_addr_i = t_addr; req_snoop_i = t_snoop;
        req_port_i = t_port; snp_en_i = t_en;
        #1 chk("req_ready_idle", req_ready_o, 1);

        ac_done = '0; cr_done = '0; rsp_done = 0; rsp_cyc = 0; fwd_cnt = 0; fin = 0;
        for (int i = 0; i < NP; i++) idx[i] = 0;

        for (int cyc = 1; cyc <= 400 && !fin; cyc++) begin
            @(negedge clk_i);
            req_valid_i = 1'b0; snp_en_i = 4'($urandom); req_addr_i = {$urandom, $urandom};
            snooping = (tgt & ~cr_done) != 0;
            in_resp  = !snooping && !rsp_done;
            any_rem  = 0;
            for (int i = 0; i < NP; i++) if (drain[i] && idx[i] < t_nb[i]) any_rem = 1;
            in_data  = rsp_done && any_rem;
            if (rsp_done && !any_rem) begin
                idle_inputs();
                #1 chk("req_ready_after", req_ready_o, 1);
                fin = 1;
            end else begin
                for (int i = 0; i < NP; i++) begin
                    ac_ready_i[i] = scripted ? (cyc >= ac_at[i]) : 1'($urandom_range(1, 0));
                    cr_valid_i[i] = tgt[i] && !cr_done[i] &&
                                    (scripted ? (cyc >= cr_at[i]) : 1'($urandom_range(1, 0)));
                    cr_resp_i[5*i +: 5] = t_resp[i];
                    cd_valid_i[i] = drain[i] && idx[i] < t_nb[i] &&
                                    (scripted || 1'($urandom_range(1, 0)));
                    cd_data_i[DW*i +: DW] = '0;
                    if (idx[i] < t_nb[i]) cd_data_i[DW*i +: DW] = t_beat[i][idx[i]];
                    cd_last_i[i] = (idx[i] == t_nb[i] - 1);
                end
                rsp_ready_i = scripted ? 1'b1 : 1'($urandom_range(1, 0));
                dat_ready_i = scripted ? 1'b1 : 1'($urandom_range(1, 0));
                #1;
                chk("req_ready_busy", req_ready_o, 0);
                chk("ac_valid", ac_valid_o, snooping ? (tgt & ~ac_done) : 4'b0);
                chk("cr_ready", cr_ready_o, snooping ? (tgt & ac_done & ~cr_done) : 4'b0);
                if (snooping) begin
                    chk("ac_addr", ac_addr_o, t_addr);
                    chk("ac_snoop", ac_snoop_o, t_snoop);
                end
                chk("rsp_valid", rsp_valid_o, in_resp);
                if (in_resp) begin
                    if (rsp_cyc == 0) rsp_cyc = cyc;
                    chk("rsp_data", rsp_data_o, fwd);
                    chk("rsp_pass_dirty", rsp_pass_dirty_o, pd);
                    chk("rsp_is_shared", rsp_is_shared_o, is);
                    chk("rsp_was_unique", rsp_was_unique_o, wu);
                    chk("rsp_err", rsp_err_o, er);
                end
                for (int i = 0; i < NP; i++)
                    exp_cd_rdy[i] = in_data && drain[i] && idx[i] < t_nb[i] &&
                                    ((fwd && i == sel) ? dat_ready_i : 1'b1);
                exp_dat_v = in_data && fwd && idx[sel] < t_nb[sel] && cd_valid_i[sel];
                chk("cd_ready", cd_ready_o, exp_cd_rdy);
                chk("dat_valid", dat_valid_o, exp_dat_v);
                if (dat_valid_o && dat_ready_i) begin
                    chk("dat_data", dat_data_o, t_beat[sel][idx[sel]]);
                    chk("dat_last", dat_last_o, idx[sel] == t_nb[sel] - 1);
                    fwd_cnt++;
                end
                ac_done |= ac_valid_o & ac_ready_i;
                cr_done |= cr_valid_i & cr_ready_o;
                if (rsp_valid_o && rsp_ready_i) rsp_done = 1;
                for (int i = 0; i < NP; i++) if (cd_valid_i[i] && cd_ready_o[i]) idx[i]++;
                if (rst_beat != 0 && fwd_cnt == rst_beat) begin
                    rst_ni = 1'b0;
                    #1 chk_reset_outputs("mid_data_rst");
                    @(negedge clk_i);
                    idle_inputs();
                    rst_ni = 1'b1;
                    #1 chk("rst_release_ready", req_ready_o, 1);
                    fin = 1;
                end
            end
        end
        if (!fin) chk("txn_timeout", 1, 0);
        if (exp_rsp_cyc != 0) chk("rsp_cycle", rsp_cyc, exp_rsp_cyc);
        if (rst_beat == 0 && fwd) chk("fwd_beats", fwd_cnt, t_nb[sel]);
    endtask

    initial begin
        idle_inputs();
        rst_ni = 1'b0;
        repeat (3) @(negedge clk_i);
        #1 chk_reset_outputs("reset");
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Initiator excluded from an all-enabled mask
        cfg_default(2'd2, 4'b1111);
        t_addr = 64'h1000; t_snoop = 4'b0001;
        run_txn(1, 3, 0);

        // Only the initiator enabled: no snoop, immediate response
        cfg_default(2'd2, 4'b0100);
        run_txn(1, 1, 0);

        // Dirty-preferred source over a lower-index clean source
        cfg_default(2'd2, 4'b1111);
        t_resp[0] = 5'b00001; t_resp[3] = 5'b00101;
        t_nb[0] = 8; t_nb[3] = 8;
        for (int b = 0; b < 8; b++) begin
            t_beat[0][b] = 64'hAAAA_AAAA_0000_0000 | 64'(b);
            t_beat[3][b] = 64'hDDDD_DDDD_0000_0000 | 64'(b);
        end
        run_txn(1, 3, 0);

        // Staggered AC/CR handshakes with mixed IsShared / WasUnique
        cfg_default(2'd2, 4'b1111);
        ac_at[0] = 1; ac_at[1] = 5; ac_at[3] = 9;
        cr_at[0] = 3; cr_at[1] = 7; cr_at[3] = 11;
        t_resp[0] = 5'b01000; t_resp[1] = 5'b10000;
        run_txn(1, 12, 0);

        // Errored data transfer is drained but never forwarded
        cfg_default(2'd0, 4'b1111);
        t_resp[1] = 5'b00011; t_nb[1] = 4;
        run_txn(1, 3, 0);

        // Reset during the third forwarded beat, then a normal transaction
        cfg_default(2'd2, 4'b1111);
        t_resp[0] = 5'b00001; t_resp[3] = 5'b00101;
        t_nb[0] = 8; t_nb[3] = 8;
        run_txn(1, 3, 3);
        cfg_default(2'd1, 4'b1111);
        t_resp[3] = 5'b01101; t_nb[3] = 3;
        run_txn(1, 3, 0);

        for (int n = 0; n < 200; n++) begin
            cfg_random();
            run_txn(0, 0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
